// File: rtl/line_fill_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : line_fill_controller_if
//  Description : Bundle of the miss request, hit notification, memory and
//                cache-array fill signals of the line fill controller.
//                master = cache/memory side, slave = the controller.
//  Revision    : 1.0  initial release
// ============================================================================
interface line_fill_controller_if #(
    parameter int WAYS    = 8,
    parameter int TAG_W   = 8,
    parameter int DATA_W  = 8,
    parameter int INDEX_W = 4
);
    // Miss request and the contents of the indexed set
    logic                      missValid;
    logic                      missReady;
    logic [INDEX_W-1:0]        missIndex;
    logic [TAG_W-1:0]          missTag;
    logic [WAYS-1:0]           valid;
    logic [WAYS-1:0]           dirty;
    logic [WAYS*TAG_W-1:0]     cacheTag;
    logic [WAYS*DATA_W-1:0]    cacheData;

    // Hit notification for replacement-state updates
    logic                      hitValid;
    logic [INDEX_W-1:0]        hitIndex;
    logic [2:0]                hitWay;

    // Memory port
    logic                      memReq;
    logic                      memWrite;
    logic [TAG_W+INDEX_W-1:0]  memAddr;
    logic [DATA_W-1:0]         memWData;
    logic                      memAck;
    logic [DATA_W-1:0]         memRData;

    // Cache array write port
    logic                      fillWe;
    logic [INDEX_W-1:0]        fillIndex;
    logic [2:0]                fillWay;
    logic [TAG_W-1:0]          fillTag;
    logic [DATA_W-1:0]         fillData;

    // Status
    logic                      busy;
    logic                      done;

    modport master (
        output missValid, missIndex, missTag, valid, dirty, cacheTag, cacheData,
        output hitValid, hitIndex, hitWay,
        output memAck, memRData,
        input  missReady, memReq, memWrite, memAddr, memWData,
        input  fillWe, fillIndex, fillWay, fillTag, fillData,
        input  busy, done
    );

    modport slave (
        input  missValid, missIndex, missTag, valid, dirty, cacheTag, cacheData,
        input  hitValid, hitIndex, hitWay,
        input  memAck, memRData,
        output missReady, memReq, memWrite, memAddr, memWData,
        output fillWe, fillIndex, fillWay, fillTag, fillData,
        output busy, done
    );
endinterface
`default_nettype wire

// File: rtl/line_fill_controller.sv
`default_nettype none
// ============================================================================
//  Module      : line_fill_controller
//  Description : Miss handler for an 8-way set-associative cache. Picks a
//                victim (first invalid way, else tree PLRU), writes it back
//                if dirty, fetches the missing line and writes it into the
//                cache arrays. Maintains per-set PLRU state from hits/fills.
//  Revision    : 1.0  initial release
// ============================================================================
module line_fill_controller #(
    parameter int WAYS    = 8,
    parameter int TAG_W   = 8,
    parameter int DATA_W  = 8,
    parameter int INDEX_W = 4
) (
    input  wire logic               clock,
    input  wire logic               resetN,
    line_fill_controller_if.slave   bus
);

    localparam int c_SETS   = 2**INDEX_W;
    localparam int c_PLRU_W = WAYS - 1;
    localparam int c_WAY_W  = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EVICT = 2'd1,
        S_FETCH = 2'd2,
        S_FILL  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // PLRU helpers. Bit k of the set state is tree node nk:
    // n0 root, n1 ways 0-3, n2 ways 4-7, n3..n6 pairs (0,1)..(6,7).
    // A node value of 0 points at its lower half.
    // ------------------------------------------------------------------
    function automatic logic [c_PLRU_W-1:0] f_plruAccess(
        input logic [c_PLRU_W-1:0] bits,
        input logic [c_WAY_W-1:0]  way
    );
        logic [c_PLRU_W-1:0] n;
        n    = bits;
        n[0] = ~way[2];
        if (!way[2]) begin
            n[1] = ~way[1];
            if (!way[1]) n[3] = ~way[0];
            else         n[4] = ~way[0];
        end else begin
            n[2] = ~way[1];
            if (!way[1]) n[5] = ~way[0];
            else         n[6] = ~way[0];
        end
        return n;
    endfunction

    function automatic logic [c_WAY_W-1:0] f_plruVictim(
        input logic [c_PLRU_W-1:0] bits
    );
        logic [c_WAY_W-1:0] w;
        w[2] = bits[0];
        if (!bits[0]) begin
            w[1] = bits[1];
            w[0] = bits[1] ? bits[4] : bits[3];
        end else begin
            w[1] = bits[2];
            w[0] = bits[2] ? bits[6] : bits[5];
        end
        return w;
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t                     r_state;
    logic                       r_missReady;
    logic                       r_busy;
    logic                       r_done;
    logic                       r_memReq;
    logic                       r_memWrite;
    logic [TAG_W+INDEX_W-1:0]   r_memAddr;
    logic [DATA_W-1:0]          r_memWData;
    logic                       r_fillWe;
    logic [INDEX_W-1:0]         r_fillIndex;
    logic [c_WAY_W-1:0]         r_fillWay;
    logic [TAG_W-1:0]           r_fillTag;
    logic [DATA_W-1:0]          r_fillData;
    logic [INDEX_W-1:0]         r_index;
    logic [TAG_W-1:0]           r_tag;
    logic [c_WAY_W-1:0]         r_way;
    logic [c_PLRU_W-1:0]        r_plru     [c_SETS];

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic                       w_accept;
    logic                       w_anyInvalid;
    logic [c_WAY_W-1:0]         w_firstInvalid;
    logic [c_WAY_W-1:0]         w_victimWay;
    logic [TAG_W-1:0]           w_victimTag;
    logic [DATA_W-1:0]          w_victimData;
    logic                       w_victimDirty;
    logic                       w_fillUpdate;
    logic [c_PLRU_W-1:0]        w_plruNext [c_SETS];

    assign w_accept     = bus.missValid && r_missReady;
    assign w_fillUpdate = (r_state == S_FILL);

    // Victim choice for the set presented with the miss
    always_comb begin
        w_anyInvalid   = 1'b0;
        w_firstInvalid = '0;
        // Scan downward so the lowest-numbered invalid way is the one kept
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!bus.valid[i]) begin
                w_anyInvalid   = 1'b1;
                w_firstInvalid = c_WAY_W'(i);
            end
        end
        w_victimWay   = w_anyInvalid ? w_firstInvalid
                                     : f_plruVictim(r_plru[bus.missIndex]);
        w_victimTag   = bus.cacheTag[int'(w_victimWay)*TAG_W +: TAG_W];
        w_victimData  = bus.cacheData[int'(w_victimWay)*DATA_W +: DATA_W];
        w_victimDirty = bus.valid[w_victimWay] & bus.dirty[w_victimWay];
    end

    // Next PLRU state: hit update first, then the fill so the fill wins
    always_comb begin
        for (int s = 0; s < c_SETS; s++) begin
            w_plruNext[s] = r_plru[s];
            if (bus.hitValid && (bus.hitIndex == INDEX_W'(s)))
                w_plruNext[s] = f_plruAccess(w_plruNext[s], bus.hitWay);
            if (w_fillUpdate && (r_index == INDEX_W'(s)))
                w_plruNext[s] = f_plruAccess(w_plruNext[s], r_way);
        end
    end

    // Per-set PLRU storage
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            for (int s = 0; s < c_SETS; s++)
                r_plru[s] <= '0;
        end else begin
            r_plru <= w_plruNext;
        end
    end

    // Miss-handling state machine with registered outputs
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_state     <= S_IDLE;
            r_missReady <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_memReq    <= 1'b0;
            r_memWrite  <= 1'b0;
            r_memAddr   <= '0;
            r_memWData  <= '0;
            r_fillWe    <= 1'b0;
            r_fillIndex <= '0;
            r_fillWay   <= '0;
            r_fillTag   <= '0;
            r_fillData  <= '0;
            r_index     <= '0;
            r_tag       <= '0;
            r_way       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_index     <= bus.missIndex;
                        r_tag       <= bus.missTag;
                        r_way       <= w_victimWay;
                        r_missReady <= 1'b0;
                        r_busy      <= 1'b1;
                        r_memReq    <= 1'b1;
                        if (w_victimDirty) begin
                            // Write-back of the victim comes first
                            r_state    <= S_EVICT;
                            r_memWrite <= 1'b1;
                            r_memAddr  <= {w_victimTag, bus.missIndex};
                            r_memWData <= w_victimData;
                        end else begin
                            r_state    <= S_FETCH;
                            r_memWrite <= 1'b0;
                            r_memAddr  <= {bus.missTag, bus.missIndex};
                        end
                    end
                end

                S_EVICT: begin
                    // memReq stays high straight into the read request
                    if (bus.memAck) begin
                        r_state    <= S_FETCH;
                        r_memWrite <= 1'b0;
                        r_memAddr  <= {r_tag, r_index};
                    end
                end

                S_FETCH: begin
                    if (bus.memAck) begin
                        r_state     <= S_FILL;
                        r_memReq    <= 1'b0;
                        r_fillWe    <= 1'b1;
                        r_done      <= 1'b1;
                        r_fillIndex <= r_index;
                        r_fillWay   <= r_way;
                        r_fillTag   <= r_tag;
                        r_fillData  <= bus.memRData;
                    end
                end

                S_FILL: begin
                    r_state     <= S_IDLE;
                    r_fillWe    <= 1'b0;
                    r_done      <= 1'b0;
                    r_busy      <= 1'b0;
                    r_missReady <= 1'b1;
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_missReady <= 1'b1;
                    r_busy      <= 1'b0;
                    r_memReq    <= 1'b0;
                    r_fillWe    <= 1'b0;
                    r_done      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.missReady = r_missReady;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.memReq    = r_memReq;
    assign bus.memWrite  = r_memWrite;
    assign bus.memAddr   = r_memAddr;
    assign bus.memWData  = r_memWData;
    assign bus.fillWe    = r_fillWe;
    assign bus.fillIndex = r_fillIndex;
    assign bus.fillWay   = r_fillWay;
    assign bus.fillTag   = r_fillTag;
    assign bus.fillData  = r_fillData;

endmodule
`default_nettype wire

// File: tb/tb_line_fill_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_line_fill_controller
//  Description : Directed self-checking bench for line_fill_controller.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_line_fill_controller;

    logic clock;
    logic resetN;
    int   nChecks;
    int   nFails;

    line_fill_controller_if #(.WAYS(8), .TAG_W(8), .DATA_W(8), .INDEX_W(4)) bus ();

    line_fill_controller #(.WAYS(8), .TAG_W(8), .DATA_W(8), .INDEX_W(4)) dut (
        .clock  (clock),
        .resetN (resetN),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        bus.missValid = 1'b0;
        bus.missIndex = '0;
        bus.missTag   = '0;
        bus.valid     = '0;
        bus.dirty     = '0;
        bus.cacheTag  = '0;
        bus.cacheData = '0;
        bus.hitValid  = 1'b0;
        bus.hitIndex  = '0;
        bus.hitWay    = '0;
        bus.memAck    = 1'b0;
        bus.memRData  = '0;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        clear_inputs();
        repeat (3) @(posedge clock);
        #1 resetN = 1'b1;
        nChecks++; if (bus.missReady !== 1'b1) begin nFails++; $display("FAIL rst_missReady: got %0h expected 1", bus.missReady); end
        nChecks++; if (bus.busy !== 1'b0) begin nFails++; $display("FAIL rst_busy: got %0h expected 0", bus.busy); end
        nChecks++; if ({bus.done, bus.fillWe} !== 2'b00) begin nFails++; $display("FAIL rst_done_fillWe: got %0h expected 0", {bus.done, bus.fillWe}); end
        nChecks++; if ({bus.memReq, bus.memWrite, bus.memAddr, bus.memWData} !== 22'h0) begin nFails++; $display("FAIL rst_mem: got %0h expected 0", {bus.memReq, bus.memWrite, bus.memAddr, bus.memWData}); end
        nChecks++; if ({bus.fillIndex, bus.fillWay, bus.fillTag, bus.fillData} !== 23'h0) begin nFails++; $display("FAIL rst_fill: got %0h expected 0", {bus.fillIndex, bus.fillWay, bus.fillTag, bus.fillData}); end

        // Hit way 0 of set 3 so its PLRU would now point at way 4
        bus.hitValid = 1'b1; bus.hitIndex = 4'd3; bus.hitWay = 3'd0;
        step();
        bus.hitValid = 1'b0;

        // Start a clean miss on set 3 and reset it mid-FETCH
        bus.missValid = 1'b1; bus.missIndex = 4'd3; bus.missTag = 8'h33;
        bus.valid = 8'hFF; bus.dirty = 8'h00;
        step();
        bus.missValid = 1'b0;
        nChecks++; if ({bus.memReq, bus.memWrite, bus.memAddr} !== {1'b1, 1'b0, 12'h333}) begin nFails++; $display("FAIL rst_fetch_req: got %0h expected %0h", {bus.memReq, bus.memWrite, bus.memAddr}, {1'b1, 1'b0, 12'h333}); end
        #2 resetN = 1'b0;
        #1;
        nChecks++; if ({bus.memReq, bus.busy, bus.missReady, bus.memAddr} !== {3'b001, 12'h000}) begin nFails++; $display("FAIL rst_async_drop: got %0h expected %0h", {bus.memReq, bus.busy, bus.missReady, bus.memAddr}, {3'b001, 12'h000}); end
        step();
        step();
        nChecks++; if ({bus.fillWe, bus.done} !== 2'b00) begin nFails++; $display("FAIL rst_no_fill: got %0h expected 0", {bus.fillWe, bus.done}); end
        resetN = 1'b1;

        // PLRU was cleared, so the full set picks way 0
        bus.missValid = 1'b1;
        step();
        bus.missValid = 1'b0;
        bus.memAck = 1'b1; bus.memRData = 8'h5A;
        step();
        bus.memAck = 1'b0;
        nChecks++; if ({bus.fillWe, bus.fillIndex, bus.fillWay} !== {1'b1, 4'd3, 3'd0}) begin nFails++; $display("FAIL rst_victim: got %0h expected %0h", {bus.fillWe, bus.fillIndex, bus.fillWay}, {1'b1, 4'd3, 3'd0}); end
        step();
    endtask

    task automatic test_invalid_priority();
        bus.missValid = 1'b1; bus.missIndex = 4'd2; bus.missTag = 8'hA5;
        bus.valid = 8'b1111_0011; bus.dirty = 8'h00;
        nChecks++; if (bus.missReady !== 1'b1) begin nFails++; $display("FAIL inv_ready: got %0h expected 1", bus.missReady); end
        step();
        bus.missValid = 1'b0;
        nChecks++; if ({bus.busy, bus.memReq, bus.memWrite, bus.memAddr} !== {3'b110, 12'hA52}) begin nFails++; $display("FAIL inv_fetch: got %0h expected %0h", {bus.busy, bus.memReq, bus.memWrite, bus.memAddr}, {3'b110, 12'hA52}); end
        bus.memAck = 1'b1; bus.memRData = 8'h3C;
        step();
        bus.memAck = 1'b0;
        nChecks++; if ({bus.fillWe, bus.done, bus.memReq} !== 3'b110) begin nFails++; $display("FAIL inv_fill_strobe: got %0h expected 6", {bus.fillWe, bus.done, bus.memReq}); end
        nChecks++; if ({bus.fillIndex, bus.fillWay, bus.fillTag, bus.fillData} !== {4'd2, 3'd2, 8'hA5, 8'h3C}) begin nFails++; $display("FAIL inv_fill_fields: got %0h expected %0h", {bus.fillIndex, bus.fillWay, bus.fillTag, bus.fillData}, {4'd2, 3'd2, 8'hA5, 8'h3C}); end
        step();
        nChecks++; if ({bus.fillWe, bus.done, bus.missReady, bus.busy} !== 4'b0010) begin nFails++; $display("FAIL inv_idle: got %0h expected 2", {bus.fillWe, bus.done, bus.missReady, bus.busy}); end
    endtask

    task automatic test_dirty_evict();
        bus.missValid = 1'b1; bus.missIndex = 4'd5; bus.missTag = 8'hC3;
        bus.valid = 8'hFF; bus.dirty = 8'b0000_0001;
        bus.cacheTag  = 64'h88776655_44332211;
        bus.cacheData = 64'hF0E0D0C0_B0A09077;
        step();
        bus.missValid = 1'b0;
        nChecks++; if ({bus.memReq, bus.memWrite, bus.memAddr, bus.memWData} !== {2'b11, 12'h115, 8'h77}) begin nFails++; $display("FAIL evict_req: got %0h expected %0h", {bus.memReq, bus.memWrite, bus.memAddr, bus.memWData}, {2'b11, 12'h115, 8'h77}); end
        for (int k = 0; k < 3; k++) begin
            step();
            nChecks++; if ({bus.memReq, bus.memWrite, bus.memAddr, bus.memWData} !== {2'b11, 12'h115, 8'h77}) begin nFails++; $display("FAIL evict_hold%0d: got %0h expected %0h", k, {bus.memReq, bus.memWrite, bus.memAddr, bus.memWData}, {2'b11, 12'h115, 8'h77}); end
        end
        bus.memAck = 1'b1;
        step();
        bus.memAck = 1'b0;
        nChecks++; if ({bus.memReq, bus.memWrite, bus.memAddr, bus.fillWe} !== {2'b10, 12'hC35, 1'b0}) begin nFails++; $display("FAIL evict_fetch: got %0h expected %0h", {bus.memReq, bus.memWrite, bus.memAddr, bus.fillWe}, {2'b10, 12'hC35, 1'b0}); end
        bus.memAck = 1'b1; bus.memRData = 8'h9E;
        step();
        bus.memAck = 1'b0;
        nChecks++; if ({bus.fillWe, bus.fillIndex, bus.fillWay, bus.fillTag, bus.fillData} !== {1'b1, 4'd5, 3'd0, 8'hC3, 8'h9E}) begin nFails++; $display("FAIL evict_fill: got %0h expected %0h", {bus.fillWe, bus.fillIndex, bus.fillWay, bus.fillTag, bus.fillData}, {1'b1, 4'd5, 3'd0, 8'hC3, 8'h9E}); end
        step();
        bus.dirty = 8'h00;
    endtask

    task automatic test_plru_sequence();
        logic [2:0] hits [4];
        hits[0] = 3'd0; hits[1] = 3'd4; hits[2] = 3'd2; hits[3] = 3'd6;
        for (int k = 0; k < 4; k++) begin
            bus.hitValid = 1'b1; bus.hitIndex = 4'd1; bus.hitWay = hits[k];
            step();
        end
        bus.hitValid = 1'b0;
        bus.missValid = 1'b1; bus.missIndex = 4'd1; bus.missTag = 8'h42;
        bus.valid = 8'hFF; bus.dirty = 8'h00;
        step();
        bus.missValid = 1'b0;
        bus.memAck = 1'b1; bus.memRData = 8'h24;
        step();
        bus.memAck = 1'b0;
        nChecks++; if ({bus.fillWe, bus.fillIndex, bus.fillWay} !== {1'b1, 4'd1, 3'd1}) begin nFails++; $display("FAIL plru_victim: got %0h expected %0h", {bus.fillWe, bus.fillIndex, bus.fillWay}, {1'b1, 4'd1, 3'd1}); end
        step();
    endtask

    task automatic test_simultaneous();
        bus.missValid = 1'b1; bus.missIndex = 4'd4; bus.missTag = 8'h44;
        bus.valid = 8'hFF; bus.dirty = 8'h00;
        step();
        bus.missValid = 1'b0;
        bus.memAck = 1'b1; bus.memRData = 8'h10;
        step();
        bus.memAck = 1'b0;
        nChecks++; if ({bus.fillWe, bus.fillIndex, bus.fillWay} !== {1'b1, 4'd4, 3'd0}) begin nFails++; $display("FAIL simul_first_fill: got %0h expected %0h", {bus.fillWe, bus.fillIndex, bus.fillWay}, {1'b1, 4'd4, 3'd0}); end
        bus.hitValid = 1'b1; bus.hitIndex = 4'd4; bus.hitWay = 3'd7;
        step();
        bus.hitValid = 1'b0;
        // Back-to-back: next miss accepted in the cycle after FILL
        bus.missValid = 1'b1; bus.missTag = 8'h45;
        nChecks++; if (bus.missReady !== 1'b1) begin nFails++; $display("FAIL b2b_ready: got %0h expected 1", bus.missReady); end
        step();
        bus.missValid = 1'b0;
        bus.memAck = 1'b1; bus.memRData = 8'h11;
        step();
        bus.memAck = 1'b0;
        nChecks++; if ({bus.fillWe, bus.fillWay, bus.fillTag} !== {1'b1, 3'd4, 8'h45}) begin nFails++; $display("FAIL simul_victim: got %0h expected %0h", {bus.fillWe, bus.fillWay, bus.fillTag}, {1'b1, 3'd4, 8'h45}); end
        step();
    endtask

    task automatic test_handshake();
        // Stray ack while idle must be ignored
        bus.memAck = 1'b1;
        step();
        bus.memAck = 1'b0;
        nChecks++; if ({bus.memReq, bus.busy, bus.fillWe} !== 3'b000) begin nFails++; $display("FAIL hs_idle_ack: got %0h expected 0", {bus.memReq, bus.busy, bus.fillWe}); end

        bus.missValid = 1'b1; bus.missIndex = 4'd6; bus.missTag = 8'h66;
        bus.valid = 8'hFF; bus.dirty = 8'h00;
        step();
        nChecks++; if ({bus.missReady, bus.busy, bus.memAddr} !== {2'b01, 12'h666}) begin nFails++; $display("FAIL hs_fetch_busy: got %0h expected %0h", {bus.missReady, bus.busy, bus.memAddr}, {2'b01, 12'h666}); end
        bus.memAck = 1'b1; bus.memRData = 8'h01;
        step();
        bus.memAck = 1'b0;
        nChecks++; if ({bus.missReady, bus.done, bus.fillWay} !== {2'b01, 3'd0}) begin nFails++; $display("FAIL hs_fill_busy: got %0h expected %0h", {bus.missReady, bus.done, bus.fillWay}, {2'b01, 3'd0}); end
        step();
        nChecks++; if ({bus.missReady, bus.busy, bus.done} !== 3'b100) begin nFails++; $display("FAIL hs_ready_again: got %0h expected 4", {bus.missReady, bus.busy, bus.done}); end
        step();
        bus.missValid = 1'b0;
        nChecks++; if ({bus.busy, bus.memReq, bus.memAddr} !== {2'b11, 12'h666}) begin nFails++; $display("FAIL hs_second_accept: got %0h expected %0h", {bus.busy, bus.memReq, bus.memAddr}, {2'b11, 12'h666}); end
        bus.memAck = 1'b1; bus.memRData = 8'h02;
        step();
        bus.memAck = 1'b0;
        nChecks++; if ({bus.fillWe, bus.fillWay, bus.fillData} !== {1'b1, 3'd4, 8'h02}) begin nFails++; $display("FAIL hs_second_fill: got %0h expected %0h", {bus.fillWe, bus.fillWay, bus.fillData}, {1'b1, 3'd4, 8'h02}); end
        step();
        nChecks++; if (bus.busy !== 1'b0) begin nFails++; $display("FAIL hs_final_idle: got %0h expected 0", bus.busy); end
    endtask

    // Watchdog so a stuck run still terminates
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nChecks = 0;
        nFails  = 0;
        test_reset();
        test_invalid_priority();
        test_dirty_evict();
        test_plru_sequence();
        test_simultaneous();
        test_handshake();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/line_fill_controller.md
# line_fill_controller

Miss-side counterpart to the 8-way hit detection path. On a reported miss it selects a victim way in the indexed set (first invalid way, otherwise tree pseudo-LRU). It writes the victim back to memory if dirty, fetches the missing line, and issues a single-cycle write of tag, data and valid into the cache arrays. It also keeps the per-set PLRU state, updated on every hit and every fill.

## Interface
- WAYS, 8, associativity; fixed at 8, with one valid bit per way.
- TAG_W, 8, tag width.
- DATA_W, 8, line data width.
- INDEX_W, 4, set index width; SETS = 2**INDEX_W.
- clock  in  1  single clock; all state changes on the rising edge.
- resetN  in  1  asynchronous, active-low reset.
- missValid / missReady  in / out  1 / 1  miss request handshake; a request is accepted when both are high.
- missIndex, missTag  in  INDEX_W, TAG_W  set and tag of the missing address.
- valid, dirty  in  8, 8  valid and dirty bits of set missIndex, sampled at accept.
- cacheTag, cacheData  in  8*TAG_W, 8*DATA_W  tags and data of set missIndex, way w at slice w, sampled at accept.
- hitValid, hitIndex, hitWay  in  1, INDEX_W, 3  hit notification used for the PLRU update.
- memReq, memWrite, memAddr, memWData  out  1, 1, TAG_W+INDEX_W, DATA_W  memory request; memAddr = {tag, index}.
- memAck, memRData  in  1, DATA_W  memory completion and read data.
- fillWe, fillIndex, fillWay, fillTag, fillData  out  1, INDEX_W, 3, TAG_W, DATA_W  cache array write; a write sets valid=1 and dirty=0.
- busy, done  out  1, 1  busy = state not IDLE; done pulses for one cycle with fillWe.

## Operation
- **States:** IDLE, EVICT, FETCH, FILL.
- **IDLE:**
  - missReady=1.
  - On accept, latch index, tag, chosen victim way, victim tag, victim data and victim dirty bit.
  - Go to EVICT if the victim is valid and dirty, else go to FETCH.
- **Victim selection:**
  - If any valid bit is 0, choose the lowest-numbered invalid way.
  - Otherwise walk the PLRU tree of the set.
- **PLRU tree:** 7 bits per set.
  - Nodes: n0 root; n1 covers ways 0-3; n2 covers ways 4-7; n3..n6 cover way pairs (0,1), (2,3), (4,5), (6,7).
  - Walk: bit 0 goes to the lower half, bit 1 goes to the upper half.
  - Access to way w sets the 3 bits on w's path so they point away from w.
- **EVICT:**
  - memReq=1, memWrite=1, memAddr={victimTag, index}, memWData=victim data.
  - On memAck, go to FETCH.
- **FETCH:**
  - memReq=1, memWrite=0, memAddr={missTag, index}.
  - On memAck, capture memRData and go to FILL.
- **FILL:**
  - fillWe=1 and done=1 for exactly one cycle, with the latched index, way and tag, and the captured data.
  - Apply the PLRU access update for the filled way, then go to IDLE.
- **Memory outputs:** stable while memReq=1. memAck is sampled only while memReq=1; memAck in other states is ignored. memAck in the first cycle of memReq is legal.
- **Hit updates:**
  - hitValid applies an access update to set hitIndex in any state.
  - Same cycle and same set as a FILL update: apply the hit update first, then the fill update, so the fill wins on shared bits.
  - Different sets: apply both.
- **missValid while busy:** ignored, because missReady=0. The request must be held by its source.

## Timing
- **Reset values:** state IDLE, missReady=1, busy=0, done=0, fillWe=0, memReq=0, memWrite=0. memAddr, memWData and all fill* outputs are 0. All PLRU bits are 0.
- **Reset mid-operation:** abort immediately. No fill write occurs and memReq drops asynchronously.
- **Clean miss:** accept at cycle T; FETCH at T+1; memAck at cycle A gives FILL at A+1 and missReady=1 at A+2. Minimum accept-to-fillWe is 2 cycles.
- **Dirty miss:** adds EVICT; minimum accept-to-fillWe is 3 cycles.
- **Back-to-back:** the next miss can be accepted in the cycle after FILL.
- **PLRU update timing:** updates take effect at the clock edge, so victim selection in the following cycle sees them.

## Test plan
- **Reset:**
  - Stimulus: resetN=0 mid-FETCH, then release; then a miss at set 3 with all ways valid and clean.
  - Required: outputs at their reset values, then victim way 0 chosen (PLRU cleared).
- **Invalid-way priority:**
  - Stimulus: valid=8'b1111_0011, dirty=0, missTag=8'hA5, index 2; memRData=8'h3C.
  - Required: fillWay=2, fillTag=8'hA5, fillData=8'h3C, fillWe at T+2 with immediate memAck.
- **Dirty eviction:**
  - Stimulus: all ways valid, way 0 dirty with tag 8'h11 and data 8'h77, index 5, memAck delayed 3 cycles.
  - Required: write {8'h11, 4'h5} with data 8'h77, then read {missTag, 4'h5}; outputs held steady during the wait.
- **PLRU sequencing:**
  - Stimulus: set 1 full; hits to ways 0, 4, 2, 6; then a miss.
  - Required: victim way 1 (PLRU bits = 7'b000_0000 plus the path updates).
- **Simultaneous events:**
  - Stimulus: hitValid with way 7 on set 4 in the same cycle as the FILL of way 0 on set 4.
  - Required: next victim for set 4 is way 4.
- **Handshake:**
  - Stimulus: missValid held high throughout a fill.
  - Required: missReady=0 while busy; no second accept until the cycle after done.
